alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised, multi-cycle RISC-V execute unit; successor to the single-cycle 32-bit ALU.
- Adds the RV32I ops that block lacks (signed SLT, SLTU, SRA) and, optionally, iterative RV32M multiply/divide.
- Sits between decode/ALU-control and writeback, with a valid/ready handshake on both sides.
- Result and flags are registered; one operation in flight at a time.

Parameters:
- XLEN, 32, operand/result width; power of 2, >= 8.
- SHW, $clog2(XLEN), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  unit can accept; high only in IDLE and rst low.
- A  in  XLEN  operand 1.
- B  in  XLEN  operand 2.
- ALU_Ctrl  in  5  operation code.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- ALU_Result  out  XLEN  registered result.
- Zero  out  1  registered; 1 iff ALU_Result == 0.
- Illegal  out  1  registered; unsupported ALU_Ctrl.

Behaviour:
- Single clock, synchronous active-high reset.
- Reset: state=IDLE, out_valid=0, ALU_Result=0, Zero=0, Illegal=0, in_ready=0 while rst high.
- rst mid-operation aborts the operation and discards its result; in_ready=1 on the first cycle after rst falls.
- FSM states: IDLE, CALC, DONE.
  - IDLE: accept when in_valid & in_ready. Operands and op are captured at that edge.
  - Basic or illegal op: go to DONE. out_valid=1 in cycle N+1 (N = acceptance cycle).
  - Mul/div op: go to CALC. CALC lasts exactly XLEN cycles (one bit per cycle, shift-add / restoring divide). Then DONE; out_valid=1 in cycle N+1+XLEN.
  - DONE: ALU_Result/Zero/Illegal held stable while out_ready=0. On out_valid & out_ready, go to IDLE. No accept in the same cycle.
  - Inputs are ignored outside IDLE.
- Basic opcodes (low 4 bits match the legacy ALU encoding):
  - 0x00 AND, 0x01 OR, 0x02 ADD, 0x03 XOR.
  - 0x04 SLL, 0x05 SRL (logical), 0x09 SRA (arithmetic).
  - 0x06 SUB.
  - 0x07 SLT (signed compare), 0x08 SLTU (unsigned compare).
- Shifts use B[SHW-1:0] only.
- ADD/SUB wrap modulo 2^XLEN; no carry or overflow flag.
- SLT/SLTU produce 0 or 1, zero-extended.
- M opcodes:
  - 0x10 MUL (low XLEN bits).
  - 0x11 MULH (signed×signed high), 0x12 MULHSU (signed A × unsigned B high), 0x13 MULHU (unsigned high).
  - 0x14 DIV, 0x15 DIVU, 0x16 REM, 0x17 REMU.
- Signed M ops: iterate on magnitudes, apply sign correction by the end of the final CALC cycle.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- Divide by zero: quotient = all ones, remainder = A. Full XLEN latency still applies.
- Signed overflow (A = most negative, B = -1): DIV = A, REM = 0.
- Any other ALU_Ctrl: ALU_Result=0, Zero=1, Illegal=1, basic-op latency.

Optional Feature:
- ALU_MULDIV_EN
  - Defined: CALC state and iterative mul/div datapath present; M opcodes behave as above.
  - Undefined: no CALC state or mul/div logic. Opcodes 0x10–0x17 are treated as illegal: ALU_Result=0, Zero=1, Illegal=1, out_valid in cycle N+1.

Test Plan:
- Basic ops, XLEN=32:
  - SUB A=5 B=5 -> 0, Zero=1, out_valid in cycle N+1.
  - SLT A=0xFFFFFFFF B=1 -> 1; SLTU same operands -> 0.
  - SRA A=0x80000000 B=0x24 (shamt 4) -> 0xF8000000.
- Multiply (ALU_MULDIV_EN), A=B=0xFFFFFFFF:
  - MUL -> 0x00000001, MULH -> 0x00000000, MULHU -> 0xFFFFFFFE.
  - out_valid exactly in cycle N+33.
- Divide:
  - DIV A=0xFFFFFFF9 (-7) B=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
  - DIVU A=5 B=0 -> 0xFFFFFFFF; REMU -> 5.
  - DIV A=0x80000000 B=0xFFFFFFFF -> 0x80000000; REM -> 0.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> ALU_Result, Zero, out_valid stable; in_ready=0 throughout; IDLE one cycle after the out_ready pulse.
- Reset mid-CALC: assert rst 10 cycles into MUL -> next cycle out_valid=0, ALU_Result=0; after rst release in_ready=1; a new ADD 3+4 -> 7 with no stale data.
- Illegal op 0x1F (and 0x10 with ALU_MULDIV_EN undefined) -> Illegal=1, ALU_Result=0, Zero=1, out_valid in cycle N+1.

Source files
------------

// File: rtl/alu_mc_if.sv
// alu_mc_if: handshake/operand/result bundle for the alu_mc execute unit.
//   in_valid/in_ready + A, B, ALU_Ctrl      : request side (master drives)
//   out_valid/out_ready + ALU_Result, Zero,
//   Illegal                                 : response side (slave drives)
// Modports: master (issuing stage / testbench), slave (alu_mc).
interface alu_mc_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic [4:0]      ALU_Ctrl;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] ALU_Result;
    logic            Zero;
    logic            Illegal;

    modport master (
        output in_valid, A, B, ALU_Ctrl, out_ready,
        input  in_ready, out_valid, ALU_Result, Zero, Illegal
    );

    modport slave (
        input  in_valid, A, B, ALU_Ctrl, out_ready,
        output in_ready, out_valid, ALU_Result, Zero, Illegal
    );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle RV32I/RV32M execute unit, one operation in flight.
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : alu_mc_if.slave (valid/ready request, valid/ready registered result)
// Basic ops and illegal codes complete one cycle after acceptance.
// Build option ALU_MULDIV_EN adds the CALC state and an iterative
// shift-add multiplier / restoring divider (XLEN cycles per operation);
// without it, codes 0x10-0x17 report Illegal like any other unknown code.
module alu_mc #(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     rst,
    alu_mc_if.slave  bus
);
    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef ALU_MULDIV_EN
        CALC = 2'd1,
`endif
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;

    logic [XLEN-1:0] basic_res;
    logic            basic_ok;
    logic [SHW-1:0]  shamt;
    logic            accept;

    assign accept = bus.in_valid & bus.in_ready;
    assign shamt  = bus.B[SHW-1:0];

    // Single-cycle ops; unknown codes yield 0 with basic_ok low.
    always_comb begin
        basic_res = '0;
        basic_ok  = 1'b1;
        case (bus.ALU_Ctrl)
            5'h00: basic_res = bus.A & bus.B;
            5'h01: basic_res = bus.A | bus.B;
            5'h02: basic_res = bus.A + bus.B;
            5'h03: basic_res = bus.A ^ bus.B;
            5'h04: basic_res = bus.A << shamt;
            5'h05: basic_res = bus.A >> shamt;
            5'h06: basic_res = bus.A - bus.B;
            5'h07: basic_res = {{(XLEN-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
            5'h08: basic_res = {{(XLEN-1){1'b0}}, bus.A < bus.B};
            5'h09: basic_res = XLEN'($signed(bus.A) >>> shamt);
            default: basic_ok = 1'b0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    // op_q: ALU_Ctrl[2:0] of the M op (0 MUL .. 3 MULHU, 4 DIV .. 7 REMU).
    // acc_q: mul -> {partial high, remaining multiplier};
    //        div -> {partial remainder, dividend/quotient bits}.
    // opnd_q holds the multiplicand or divisor magnitude.
    logic [2:0]        op_q, op_d;
    logic [2*XLEN-1:0] acc_q, acc_d, acc_nx, prod_fix;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic              neg_q, neg_d;
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic              is_mop, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag, quo, rem, fin_res;
    logic [XLEN:0]     sum, r_sh, diff;

    assign is_mop = (bus.ALU_Ctrl[4:3] == 2'b10);
    // Signed A: MULH, MULHSU, DIV, REM; signed B: MULH, DIV, REM.
    assign a_neg  = bus.A[XLEN-1] & (bus.ALU_Ctrl[2:0] inside {3'd1, 3'd2, 3'd4, 3'd6});
    assign b_neg  = bus.B[XLEN-1] & (bus.ALU_Ctrl[2:0] inside {3'd1, 3'd4, 3'd6});
    assign a_mag  = a_neg ? -bus.A : bus.A;
    assign b_mag  = b_neg ? -bus.B : bus.B;

    always_comb begin
        sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        r_sh = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        diff = r_sh - {1'b0, opnd_q};
        if (!op_q[2]) begin
            acc_nx = {sum, acc_q[XLEN-1:1]};
        end else if (!diff[XLEN]) begin
            acc_nx = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_nx = {r_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end
        prod_fix = neg_q ? -acc_nx : acc_nx;
        quo      = neg_q ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
        rem      = neg_q ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
        case (op_q)
            3'd0:                 fin_res = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3:     fin_res = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:           fin_res = quo;
            default:              fin_res = rem;
        endcase
    end
`endif

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
`ifdef ALU_MULDIV_EN
        op_d      = op_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        neg_d     = neg_q;
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = DONE;
                    result_d  = basic_res;
                    zero_d    = (basic_res == '0);
                    illegal_d = ~basic_ok;
`ifdef ALU_MULDIV_EN
                    if (is_mop) begin
                        state_d   = CALC;
                        illegal_d = 1'b0;
                        op_d      = bus.ALU_Ctrl[2:0];
                        cnt_d     = '0;
                        if (!bus.ALU_Ctrl[2]) begin
                            acc_d  = {{XLEN{1'b0}}, b_mag};
                            opnd_d = a_mag;
                            neg_d  = a_neg ^ b_neg;
                        end else begin
                            acc_d  = {{XLEN{1'b0}}, a_mag};
                            opnd_d = b_mag;
                            // Divide by zero keeps the all-ones quotient
                            // unnegated; the remainder keeps A's sign.
                            neg_d  = bus.ALU_Ctrl[1] ? a_neg
                                                     : ((a_neg ^ b_neg) & (bus.B != '0));
                        end
                    end
`endif
                end
            end
`ifdef ALU_MULDIV_EN
            CALC: begin
                acc_d = acc_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SHW'(XLEN-1)) begin
                    state_d   = DONE;
                    result_d  = fin_res;
                    zero_d    = (fin_res == '0);
                    illegal_d = 1'b0;
                end
            end
`endif
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
`ifdef ALU_MULDIV_EN
            op_q      <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            neg_q     <= 1'b0;
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
`ifdef ALU_MULDIV_EN
            op_q      <= op_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            neg_q     <= neg_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign bus.in_ready   = (state_q == IDLE) & ~rst;
    assign bus.out_valid  = (state_q == DONE);
    assign bus.ALU_Result = result_q;
    assign bus.Zero       = zero_q;
    assign bus.Illegal    = illegal_q;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: self-checking bench for alu_mc (XLEN=32), directed cases plus
// randomized operations against an arithmetic reference model. Honors
// ALU_MULDIV_EN the same way the design does.
module tb_alu_mc;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    alu_mc_if #(.XLEN(XLEN)) bus ();
    alu_mc #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference: result, illegal flag and acceptance-to-out_valid latency.
    function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic ill, output int lat);
        longint      sa, sb;
        logic [63:0] ua, ub, p;
        logic [4:0]  sh;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        sh  = b[4:0];
        p   = '0;
        res = '0;
        ill = 1'b0;
        lat = 1;
        case (op)
            5'h00: res = a & b;
            5'h01: res = a | b;
            5'h02: res = a + b;
            5'h03: res = a ^ b;
            5'h04: res = a << sh;
            5'h05: res = a >> sh;
            5'h06: res = a - b;
            5'h07: res = (sa < sb) ? 32'd1 : 32'd0;
            5'h08: res = (a < b) ? 32'd1 : 32'd0;
            5'h09: res = 32'($signed(a) >>> sh);
`ifdef ALU_MULDIV_EN
            5'h10: begin p = ua * ub;                 res = p[31:0];  end
            5'h11: begin p = 64'(sa * sb);            res = p[63:32]; end
            5'h12: begin p = 64'(sa * longint'(ua));  res = p[63:32]; end
            5'h13: begin p = ua * ub;                 res = p[63:32]; end
            5'h14: if (b == 0) res = '1;
                   else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = a;
                   else res = 32'(sa / sb);
            5'h15: res = (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'h16: if (b == 0) res = a;
                   else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = '0;
                   else res = 32'(sa % sb);
            5'h17: res = (b == 0) ? a : a % b;
`endif
            default: ill = 1'b1;
        endcase
`ifdef ALU_MULDIV_EN
        if (op[4:3] == 2'b10) lat = 1 + XLEN;
`endif
    endfunction

    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        logic [31:0] er;
        logic        ei;
        int          el;
        int          lat;
        model(op, a, b, er, ei, el);
        @(negedge clk);
        check("in_ready_idle", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.A = a;
        bus.B = b;
        bus.ALU_Ctrl = op;
        @(posedge clk);
        #1;
        // Keep presenting junk; the unit must ignore it until back in IDLE.
        bus.A = $urandom();
        bus.B = $urandom();
        bus.ALU_Ctrl = 5'($urandom());
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, el);
        check("result", bus.ALU_Result, er);
        check("zero", bus.Zero, (er == 0));
        check("illegal", bus.Illegal, ei);
        repeat (hold) begin
            @(negedge clk);
            check("hold_valid", bus.out_valid, 1);
            check("hold_in_ready", bus.in_ready, 0);
            check("hold_result", bus.ALU_Result, er);
            check("hold_zero", bus.Zero, (er == 0));
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("idle_out_valid", bus.out_valid, 0);
        check("idle_in_ready", bus.in_ready, 1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    logic [4:0] op_tab [19];

    initial begin
        op_tab = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09,
                   5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17, 5'h1F};
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.ALU_Ctrl  = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result", bus.ALU_Result, 0);
        check("rst_zero", bus.Zero, 0);
        check("rst_illegal", bus.Illegal, 0);
        check("rst_in_ready", bus.in_ready, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", bus.in_ready, 1);

        run_op(5'h06, 32'd5, 32'd5, 0);
        run_op(5'h07, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(5'h08, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(5'h09, 32'h8000_0000, 32'h24, 0);
        run_op(5'h04, 32'h0000_0001, 32'h3F, 0);
        run_op(5'h10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(5'h11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(5'h13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(5'h12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(5'h14, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(5'h16, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(5'h15, 32'd5, 32'd0, 0);
        run_op(5'h17, 32'd5, 32'd0, 0);
        run_op(5'h14, 32'hFFFF_FFF9, 32'd0, 0);
        run_op(5'h16, 32'hFFFF_FFF9, 32'd0, 0);
        run_op(5'h14, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(5'h16, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(5'h1F, 32'd9, 32'd3, 0);
        run_op(5'h0A, 32'd9, 32'd3, 0);
        run_op(5'h02, 32'h1234_5678, 32'h1111_1111, 5);
        run_op(5'h10, 32'd7, 32'd6, 5);

        // Reset ten cycles into an operation: result must be discarded.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.A = $urandom();
        bus.B = $urandom() | 32'h1;
        bus.ALU_Ctrl = 5'h10;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_result", bus.ALU_Result, 0);
        check("abort_illegal", bus.Illegal, 0);
        check("abort_in_ready", bus.in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_release_in_ready", bus.in_ready, 1);
        run_op(5'h02, 32'd3, 32'd4, 0);

        for (int i = 0; i < 150; i++) begin
            logic [4:0] op;
            if ($urandom_range(0, 7) == 0) op = 5'($urandom());
            else op = op_tab[$urandom_range(0, 18)];
            run_op(op, pick(), pick(), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
